csr_file: RTL and testbench

//  Control/status register file answering the WB stage's CSR and exception interface.
//  - Serves combinational CSR reads and masked CSR writes.
//  - Commits exception entry and ERTN state changes.
//  - Samples interrupt lines and supplies redirect PCs (ex_entry, ertn_entry) and has_int to the front of the pipe.

---
 rtl/csr_file.sv | 187 ++++++++++++++++++
 tb/tb_csr_file.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// Control/status register file for the WB stage: CSR reads/writes, exception and ERTN commit, interrupt sampling.
// Build option: define CSR_TIMER_EN to implement the TCFG/TVAL/TICLR timer.
module csr_file #(
  parameter logic [31:0] TID_INIT    = 32'h0,
  parameter int          TIMER_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_re,
  input  logic [13:0] csr_num,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic        ertn_flush,
  input  logic [31:0] wb_pc,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_vaddr,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_entry,
  output logic        has_int
);

  localparam logic [13:0] CSR_CRMD   = 14'h0;
  localparam logic [13:0] CSR_PRMD   = 14'h1;
  localparam logic [13:0] CSR_ECFG   = 14'h4;
  localparam logic [13:0] CSR_ESTAT  = 14'h5;
  localparam logic [13:0] CSR_ERA    = 14'h6;
  localparam logic [13:0] CSR_BADV   = 14'h7;
  localparam logic [13:0] CSR_EENTRY = 14'hC;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_SAVE1  = 14'h31;
  localparam logic [13:0] CSR_SAVE2  = 14'h32;
  localparam logic [13:0] CSR_SAVE3  = 14'h33;
  localparam logic [13:0] CSR_TID    = 14'h40;
  localparam logic [13:0] CSR_TCFG   = 14'h41;
  localparam logic [13:0] CSR_TVAL   = 14'h42;
  localparam logic [13:0] CSR_TICLR  = 14'h44;

  logic [4:0]  crmd;
  logic [2:0]  prmd;
  logic [12:0] ecfg_lie;
  logic [1:0]  is_sw;
  logic [7:0]  is_hw;
  logic        is_ipi;
  logic        is_ti;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  logic [31:0] era;
  logic [31:0] badv;
  logic [25:0] eentry;
  logic [31:0] save0, save1, save2, save3;
  logic [31:0] tid;
  logic [31:0] tcfg_rd;
  logic [31:0] tval_rd;
  logic [12:0] estat_is;
  logic [31:0] wnew;
  logic        wr_en;

  assign estat_is = {is_ipi, is_ti, 1'b0, is_hw, is_sw};
  // Software writes only land on cycles with no exception or ERTN commit.
  assign wr_en    = csr_we & ~wb_ex & ~ertn_flush;
  // csr_rvalue is the current value of csr_num, so the merge reuses the read mux.
  assign wnew     = (csr_rvalue & ~csr_wmask) | (csr_wvalue & csr_wmask);

  assign ex_entry   = {eentry, 6'b0};
  assign ertn_entry = era;
  assign has_int    = crmd[2] & (|(estat_is & ecfg_lie));

  always_comb begin
    csr_rvalue = 32'h0;
    case (csr_num)
      CSR_CRMD:   csr_rvalue = {27'b0, crmd};
      CSR_PRMD:   csr_rvalue = {29'b0, prmd};
      CSR_ECFG:   csr_rvalue = {19'b0, ecfg_lie};
      CSR_ESTAT:  csr_rvalue = {1'b0, esubcode, ecode, 3'b0, estat_is};
      CSR_ERA:    csr_rvalue = era;
      CSR_BADV:   csr_rvalue = badv;
      CSR_EENTRY: csr_rvalue = {eentry, 6'b0};
      CSR_SAVE0:  csr_rvalue = save0;
      CSR_SAVE1:  csr_rvalue = save1;
      CSR_SAVE2:  csr_rvalue = save2;
      CSR_SAVE3:  csr_rvalue = save3;
      CSR_TID:    csr_rvalue = tid;
      CSR_TCFG:   csr_rvalue = tcfg_rd;
      CSR_TVAL:   csr_rvalue = tval_rd;
      default:    csr_rvalue = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crmd     <= 5'h8;
      prmd     <= 3'h0;
      ecfg_lie <= 13'h0;
      is_sw    <= 2'h0;
      is_hw    <= 8'h0;
      is_ipi   <= 1'b0;
      ecode    <= 6'h0;
      esubcode <= 9'h0;
      era      <= 32'h0;
      badv     <= 32'h0;
      eentry   <= 26'h0;
      save0    <= 32'h0;
      save1    <= 32'h0;
      save2    <= 32'h0;
      save3    <= 32'h0;
      tid      <= TID_INIT;
    end else begin
      is_hw  <= hw_int_in;
      is_ipi <= ipi_int_in;
      if (wb_ex) begin
        prmd      <= crmd[2:0];
        crmd[2:0] <= 3'b0;
        era       <= wb_pc;
        ecode     <= wb_ecode;
        esubcode  <= wb_esubcode;
        if (wb_ecode == 6'h8 || wb_ecode == 6'h9) badv <= wb_vaddr;
      end else if (ertn_flush) begin
        crmd[2:0] <= prmd;
      end else if (csr_we) begin
        case (csr_num)
          CSR_CRMD:   crmd     <= wnew[4:0];
          CSR_PRMD:   prmd     <= wnew[2:0];
          CSR_ECFG:   ecfg_lie <= wnew[12:0] & 13'h1BFF;
          CSR_ESTAT:  is_sw    <= wnew[1:0];
          CSR_ERA:    era      <= wnew;
          CSR_BADV:   badv     <= wnew;
          CSR_EENTRY: eentry   <= wnew[31:6];
          CSR_SAVE0:  save0    <= wnew;
          CSR_SAVE1:  save1    <= wnew;
          CSR_SAVE2:  save2    <= wnew;
          CSR_SAVE3:  save3    <= wnew;
          CSR_TID:    tid      <= wnew;
          default:    ;
        endcase
      end
    end
  end

`ifdef CSR_TIMER_EN
  logic [TIMER_WIDTH-1:0] tcfg;
  logic [TIMER_WIDTH-1:0] tval;
  logic                   tcfg_wr;
  logic                   ticlr_wr;
  logic                   fire;

  assign tcfg_wr  = wr_en && csr_num == CSR_TCFG;
  assign ticlr_wr = wr_en && csr_num == CSR_TICLR && csr_wvalue[0] && csr_wmask[0];
  assign fire     = tcfg[0] && tval == '0;
  assign tcfg_rd  = 32'(tcfg);
  assign tval_rd  = 32'(tval);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcfg  <= '0;
      tval  <= '0;
      is_ti <= 1'b0;
    end else begin
      if (fire)          is_ti <= 1'b1;
      else if (ticlr_wr) is_ti <= 1'b0;
      if (tcfg_wr) begin
        tcfg <= wnew[TIMER_WIDTH-1:0];
        tval <= {wnew[TIMER_WIDTH-1:2], 2'b00};
      end else if (fire) begin
        if (tcfg[1]) begin
          tval <= {tcfg[TIMER_WIDTH-1:2], 2'b00};
        end else begin
          tval    <= '1;
          tcfg[0] <= 1'b0;
        end
      end else if (tcfg[0]) begin
        tval <= tval - 1'b1;
      end
    end
  end
`else
  assign tcfg_rd = 32'h0;
  assign tval_rd = 32'h0;
  assign is_ti   = 1'b0;
`endif

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file: reset values, masked writes, exception/ERTN commit,
// commit priority, interrupt sampling and (with CSR_TIMER_EN) the one-shot timer.
module tb_csr_file;

  logic        clk;
  logic        rst;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic        ertn_flush;
  logic [31:0] wb_pc;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_vaddr;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        has_int;

  int checks;
  int errors;

  csr_file #(.TID_INIT(32'h1234_5678), .TIMER_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_pc(wb_pc), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_vaddr(wb_vaddr), .hw_int_in(hw_int_in),
    .ipi_int_in(ipi_int_in), .ex_entry(ex_entry), .ertn_entry(ertn_entry), .has_int(has_int)
  );

  // clock / reset
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // driver tasks; inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_csr(input string tag, input logic [13:0] num, input logic [31:0] exp);
    csr_re  = 1'b1;
    csr_num = num;
    #1;
    check(tag, csr_rvalue, exp);
    csr_re  = 1'b0;
  endtask

  task automatic csr_write(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    csr_we     = 1'b1;
    csr_num    = num;
    csr_wmask  = mask;
    csr_wvalue = val;
    tick();
    csr_we     = 1'b0;
  endtask

  task automatic raise_ex(input logic [31:0] pc, input logic [5:0] code,
                          input logic [8:0] sub, input logic [31:0] va);
    wb_ex       = 1'b1;
    wb_pc       = pc;
    wb_ecode    = code;
    wb_esubcode = sub;
    wb_vaddr    = va;
    tick();
    wb_ex       = 1'b0;
    csr_we      = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; csr_re = 1'b0; csr_num = 14'h0; csr_we = 1'b0; csr_wmask = 32'h0;
    csr_wvalue = 32'h0; wb_ex = 1'b0; ertn_flush = 1'b0; wb_pc = 32'h0; wb_ecode = 6'h0;
    wb_esubcode = 9'h0; wb_vaddr = 32'h0; hw_int_in = 8'h0; ipi_int_in = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // reset state
    check_csr("rst_crmd", 14'h0, 32'h0000_0008);
    check_csr("rst_prmd", 14'h1, 32'h0);
    check_csr("rst_estat", 14'h5, 32'h0);
    check_csr("rst_era", 14'h6, 32'h0);
    check_csr("rst_tid", 14'h40, 32'h1234_5678);
    check("rst_has_int", {31'b0, has_int}, 32'h0);
    check("rst_ex_entry", ex_entry, 32'h0);
    check("rst_ertn_entry", ertn_entry, 32'h0);

    // masked writes and writable-field masks
    csr_write(14'h30, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    csr_write(14'h30, 32'h0000_FFFF, 32'h0);
    check_csr("save0_masked", 14'h30, 32'hFFFF_0000);
    csr_write(14'h33, 32'hFF00_FF00, 32'hA5A5_A5A5);
    check_csr("save3_masked", 14'h33, 32'hA500_A500);
    csr_write(14'h4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_csr("ecfg_ro_bit10", 14'h4, 32'h0000_1BFF);
    csr_write(14'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_csr("eentry_low_ro", 14'hC, 32'hFFFF_FFC0);
    check("ex_entry", ex_entry, 32'hFFFF_FFC0);
    csr_write(14'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_csr("unimpl_reads_0", 14'h2, 32'h0);
    csr_write(14'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_csr("estat_sw_is", 14'h5, 32'h0000_0003);
    csr_write(14'h5, 32'h0000_0003, 32'h0);
    check_csr("estat_sw_clr", 14'h5, 32'h0);

    // exception commit with ALE
    csr_write(14'h0, 32'h0000_0007, 32'h0000_0007);
    check_csr("crmd_set", 14'h0, 32'h0000_000F);
    raise_ex(32'h1C00_0100, 6'h9, 9'h5, 32'h0000_1234);
    check_csr("ex_crmd", 14'h0, 32'h0000_0008);
    check_csr("ex_prmd", 14'h1, 32'h0000_0007);
    check_csr("ex_era", 14'h6, 32'h1C00_0100);
    check_csr("ex_badv", 14'h7, 32'h0000_1234);
    check_csr("ex_estat", 14'h5, 32'h0149_0000);

    // ERTN restores PLV/IE
    ertn_flush = 1'b1;
    tick();
    ertn_flush = 1'b0;
    check_csr("ertn_crmd", 14'h0, 32'h0000_000F);
    check("ertn_entry", ertn_entry, 32'h1C00_0100);

    // wb_ex beats a same-cycle ERA write; non-ADE/ALE code leaves BADV
    csr_we = 1'b1; csr_num = 14'h6; csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'h0000_DEAD;
    raise_ex(32'h1C00_0200, 6'h1, 9'h0, 32'h0000_5555);
    check_csr("prio_era", 14'h6, 32'h1C00_0200);
    check_csr("prio_badv", 14'h7, 32'h0000_1234);
    check_csr("prio_prmd", 14'h1, 32'h0000_0007);
    check_csr("prio_crmd", 14'h0, 32'h0000_0008);

    // ertn_flush beats a same-cycle SAVE1 write
    csr_we = 1'b1; csr_num = 14'h31; csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'h0000_AAAA;
    ertn_flush = 1'b1;
    tick();
    ertn_flush = 1'b0;
    csr_we = 1'b0;
    check_csr("ertn_drops_we", 14'h31, 32'h0);
    check_csr("ertn2_crmd", 14'h0, 32'h0000_000F);

    // interrupt sampling and has_int
    hw_int_in = 8'h01;
    tick();
    check_csr("hw_int_is2", 14'h5, 32'h0001_0004);
    check("has_int_hw", {31'b0, has_int}, 32'h1);
    csr_write(14'h4, 32'h0000_0004, 32'h0);
    check("has_int_masked", {31'b0, has_int}, 32'h0);
    hw_int_in = 8'h00;
    ipi_int_in = 1'b1;
    tick();
    check_csr("ipi_is12", 14'h5, 32'h0001_1000);
    check("has_int_ipi", {31'b0, has_int}, 32'h1);
    csr_write(14'h0, 32'h0000_0004, 32'h0);
    check("has_int_ie0", {31'b0, has_int}, 32'h0);
    ipi_int_in = 1'b0;
    csr_write(14'h4, 32'hFFFF_FFFF, 32'h0000_0800);
    csr_write(14'h0, 32'h0000_0004, 32'h0000_0004);
    check_csr("ecfg_lie11", 14'h4, 32'h0000_0800);

`ifdef CSR_TIMER_EN
    // one-shot timer, InitVal 3
    csr_write(14'h41, 32'hFFFF_FFFF, 32'h0000_000D);
    check_csr("tcfg_wr", 14'h41, 32'h0000_000D);
    check_csr("tval_load", 14'h42, 32'h0000_000C);
    repeat (11) tick();
    check_csr("tval_11", 14'h42, 32'h0000_0001);
    tick();
    check_csr("tval_12", 14'h42, 32'h0);
    check_csr("ti_not_yet", 14'h5, 32'h0001_0000);
    check("has_int_not_yet", {31'b0, has_int}, 32'h0);
    repeat (2) tick();
    check_csr("ti_fired", 14'h5, 32'h0001_0800);
    check("has_int_timer", {31'b0, has_int}, 32'h1);
    check_csr("tval_oneshot", 14'h42, 32'hFFFF_FFFF);
    check_csr("tcfg_en_clr", 14'h41, 32'h0000_000C);
    csr_write(14'h44, 32'hFFFF_FFFF, 32'h0000_0001);
    check_csr("ticlr_clr", 14'h5, 32'h0001_0000);
    check("has_int_cleared", {31'b0, has_int}, 32'h0);
    check_csr("ticlr_reads_0", 14'h44, 32'h0);
`else
    csr_write(14'h41, 32'hFFFF_FFFF, 32'h0000_000D);
    check_csr("tcfg_absent", 14'h41, 32'h0);
    repeat (14) tick();
    check_csr("tval_absent", 14'h42, 32'h0);
    check_csr("no_timer_is11", 14'h5, 32'h0001_0000);
    check("has_int_no_timer", {31'b0, has_int}, 32'h0);
`endif

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
